ram_march_bist: RTL and testbench

//   Built-in self-test initiator for the 1W/1R synchronous RAM (ram). Drives the RAM write and read ports,

---
 rtl/ram_march_bist.sv | 146 ++++++++++++++
 tb/tb_ram_march_bist.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_bist.sv
// March BIST initiator for a 1W/1R synchronous RAM: W0 asc, R0 asc, W1 asc, R1 desc.
// Reads are checked through a valid/address delay line matched to the RAM read latency.
module ram_march_bist #(
  parameter int                 DATA_W  = 8,
  parameter int                 ADDR_W  = 4,
  parameter logic [DATA_W-1:0]  PATTERN = 8'h55,
  parameter int                 RD_LAT  = 1,
  parameter int                 ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_reg;
  // Stage 0 tags the address currently on rd_addr; stage RD_LAT lines up with rd_data.
  logic [RD_LAT:0]   vld_reg;
  logic [RD_LAT:0]   last_reg;
  logic [ADDR_W-1:0] addr_reg [1:RD_LAT];

  logic [DATA_W-1:0] expected;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;
  logic [ADDR_W-1:0] addr_step;
  logic [ADDR_W-1:0] end_addr;

  always_comb begin
    expected  = (state_reg == R1) ? ~PATTERN : PATTERN;
    mismatch  = vld_reg[RD_LAT] && (rd_data != expected);
    err_next  = err_count;
    if (mismatch && (err_count != '1)) begin
      err_next = err_count + ERR_W'(1);
    end
    addr_step = (state_reg == R1) ? (rd_addr - ADDR_W'(1)) : (rd_addr + ADDR_W'(1));
    end_addr  = (state_reg == R1) ? '0 : LAST_ADDR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      vld_reg   <= '0;
      last_reg  <= '0;
      for (int i = 1; i <= RD_LAT; i++) begin
        addr_reg[i] <= '0;
      end
    end else begin
      vld_reg[0]  <= 1'b0;
      last_reg[0] <= 1'b0;
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_reg[i]  <= vld_reg[i-1];
        last_reg[i] <= last_reg[i-1];
      end
      addr_reg[1] <= rd_addr;
      for (int i = 2; i <= RD_LAT; i++) begin
        addr_reg[i] <= addr_reg[i-1];
      end

      err_count <= err_next;
      if (mismatch && (err_count == '0)) begin
        fail_addr <= addr_reg[RD_LAT];
        fail_data <= rd_data;
      end

      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg <= W0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            wr_en     <= 1'b1;
            wr_addr   <= '0;
            wr_data   <= PATTERN;
          end
        end
        W0, W1: begin
          if (wr_addr == LAST_ADDR) begin
            wr_en       <= 1'b0;
            vld_reg[0]  <= 1'b1;
            last_reg[0] <= 1'b0;
            if (state_reg == W0) begin
              state_reg <= R0;
              rd_addr   <= '0;
            end else begin
              state_reg <= R1;
              rd_addr   <= LAST_ADDR;
            end
          end else begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end
        R0, R1: begin
          if (vld_reg[0] && !last_reg[0]) begin
            rd_addr     <= addr_step;
            vld_reg[0]  <= 1'b1;
            last_reg[0] <= (addr_step == end_addr);
          end
          // The phase closes on the edge that checks its final read.
          if (vld_reg[RD_LAT] && last_reg[RD_LAT]) begin
            if (state_reg == R0) begin
              state_reg <= W1;
              wr_en     <= 1'b1;
              wr_addr   <= '0;
              wr_data   <= ~PATTERN;
            end else begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_next == '0);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: two instances (read latency 1 and 2) on behavioural RAMs with
// injectable stuck-at-0 bits; outputs are checked every cycle of a run against a timeline model.
module tb_ram_march_bist;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int EW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s     [2];
  logic          start_s   [2];
  logic          wr_en_s   [2];
  logic [AW-1:0] wr_addr_s [2];
  logic [DW-1:0] wr_data_s [2];
  logic [AW-1:0] rd_addr_s [2];
  logic [DW-1:0] rd_data_s [2];
  logic          busy_s    [2];
  logic          done_s    [2];
  logic          pass_s    [2];
  logic [EW-1:0] err_s     [2];
  logic [AW-1:0] fa_s      [2];
  logic [DW-1:0] fd_s      [2];

  ram_march_bist #(.DATA_W(DW), .ADDR_W(AW), .PATTERN(8'h55), .RD_LAT(1), .ERR_W(EW)) dut_lat1 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]),
    .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]), .wr_data(wr_data_s[0]),
    .rd_addr(rd_addr_s[0]), .rd_data(rd_data_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_count(err_s[0]), .fail_addr(fa_s[0]), .fail_data(fd_s[0]));

  ram_march_bist #(.DATA_W(DW), .ADDR_W(AW), .PATTERN(8'h55), .RD_LAT(2), .ERR_W(EW)) dut_lat2 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]),
    .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]), .wr_data(wr_data_s[1]),
    .rd_addr(rd_addr_s[1]), .rd_data(rd_data_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_count(err_s[1]), .fail_addr(fa_s[1]), .fail_data(fd_s[1]));

  // RAM models: instance 0 has one read register, instance 1 has two.
  logic [DW-1:0] mem   [2][DEPTH];
  logic [DW-1:0] stuck [2][DEPTH];
  logic [DW-1:0] rd_p1 [2];
  logic [DW-1:0] rd_p2 [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en_s[i]) mem[i][wr_addr_s[i]] <= wr_data_s[i];
      rd_p1[i] <= mem[i][rd_addr_s[i]] & ~stuck[i][rd_addr_s[i]];
      rd_p2[i] <= rd_p1[i];
    end
  end
  assign rd_data_s[0] = rd_p1[0];
  assign rd_data_s[1] = rd_p2[1];

  int vectors    = 0;
  int miscompares = 0;

  int kc         [2];
  bit trk        [2];
  int first_done [2];
  int exp_err    [2];
  int exp_fa     [2];
  int exp_fd     [2];
  bit exp_pass   [2];

  task automatic chk(input string nm, input int inst, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d k=%0d: got %0h expected %0h", nm, inst, k, act, exp);
    end
  endtask

  // Expected DUT outputs after edge k of a run, from the march timeline.
  task automatic check_cycle(input int i, input int k);
    int lat, t_done, r0s, w1s, r1s;
    logic          ew, rv;
    logic [AW-1:0] ea, ra;
    logic [DW-1:0] ed;
    lat    = i + 1;
    t_done = 4 * DEPTH + 2 * lat;
    r0s    = DEPTH;
    w1s    = 2 * DEPTH + lat;
    r1s    = 3 * DEPTH + lat;
    ew = 1'b0; rv = 1'b0; ea = '0; ra = '0; ed = '0;
    if (k < DEPTH) begin
      ew = 1'b1; ea = AW'(k); ed = 8'h55;
    end else if (k >= w1s && k < w1s + DEPTH) begin
      ew = 1'b1; ea = AW'(k - w1s); ed = 8'hAA;
    end
    if (k >= r0s && k < r0s + DEPTH) begin
      rv = 1'b1; ra = AW'(k - r0s);
    end else if (k >= r1s && k < r1s + DEPTH) begin
      rv = 1'b1; ra = AW'(DEPTH - 1 - (k - r1s));
    end
    chk("wr_en", i, k, wr_en_s[i], ew);
    if (ew) begin
      chk("wr_addr", i, k, wr_addr_s[i], ea);
      chk("wr_data", i, k, wr_data_s[i], ed);
    end
    if (rv) chk("rd_addr", i, k, rd_addr_s[i], ra);
    chk("busy", i, k, busy_s[i], k < t_done);
    chk("done", i, k, done_s[i], k >= t_done);
    if (k == 0) begin
      chk("err_clr", i, k, err_s[i], 0);
      chk("fa_clr", i, k, fa_s[i], 0);
      chk("fd_clr", i, k, fd_s[i], 0);
    end
    if (k < t_done) begin
      chk("pass_busy", i, k, pass_s[i], 0);
    end else begin
      chk("pass", i, k, pass_s[i], exp_pass[i]);
      chk("err_count", i, k, err_s[i], exp_err[i]);
      chk("fail_addr", i, k, fa_s[i], exp_fa[i]);
      chk("fail_data", i, k, fd_s[i], exp_fd[i]);
    end
    if (done_s[i] && first_done[i] < 0) first_done[i] = k;
    if (k >= t_done + 2) trk[i] = 1'b0;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) if (trk[i]) kc[i]++;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (trk[i] && kc[i] >= 0) check_cycle(i, kc[i]);
  end

  task automatic do_start(input int i);
    logic [DW-1:0] v;
    @(negedge clk);
    exp_err[i] = 0; exp_fa[i] = 0; exp_fd[i] = 0;
    for (int a = 0; a < DEPTH; a++) begin
      v = 8'h55 & ~stuck[i][a];
      if (v != 8'h55) begin
        if (exp_err[i] == 0) begin exp_fa[i] = a; exp_fd[i] = v; end
        exp_err[i]++;
      end
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      v = 8'hAA & ~stuck[i][a];
      if (v != 8'hAA) begin
        if (exp_err[i] == 0) begin exp_fa[i] = a; exp_fd[i] = v; end
        exp_err[i]++;
      end
    end
    exp_pass[i]   = (exp_err[i] == 0);
    first_done[i] = -1;
    kc[i]         = -1;
    trk[i]        = 1'b1;
    start_s[i]    = 1'b1;
    @(negedge clk);
    start_s[i]    = 1'b0;
  endtask

  task automatic wait_run(input int i);
    for (int n = 0; n < 300 && trk[i]; n++) @(negedge clk);
    chk("run_timeout", i, kc[i], trk[i], 0);
    trk[i] = 1'b0;
    $display("run inst%0d: done_k=%0d pass=%0b err=%0d fail_addr=%0h fail_data=%0h",
             i, first_done[i], pass_s[i], err_s[i], fa_s[i], fd_s[i]);
  endtask

  task automatic wait_k(input int i, input int target);
    for (int n = 0; n < 300 && kc[i] != target; n++) @(negedge clk);
    chk("wait_k", i, kc[i], kc[i], target);
  endtask

  task automatic check_idle_zero(input int i, input string tag);
    chk({tag, "_busy"}, i, -1, busy_s[i], 0);
    chk({tag, "_done"}, i, -1, done_s[i], 0);
    chk({tag, "_pass"}, i, -1, pass_s[i], 0);
    chk({tag, "_err"}, i, -1, err_s[i], 0);
    chk({tag, "_fa"}, i, -1, fa_s[i], 0);
    chk({tag, "_fd"}, i, -1, fd_s[i], 0);
    chk({tag, "_wr_en"}, i, -1, wr_en_s[i], 0);
    chk({tag, "_wr_addr"}, i, -1, wr_addr_s[i], 0);
    chk({tag, "_wr_data"}, i, -1, wr_data_s[i], 0);
    chk({tag, "_rd_addr"}, i, -1, rd_addr_s[i], 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; start_s[i] = 1'b0; trk[i] = 1'b0; kc[i] = -1; first_done[i] = -1;
      for (int a = 0; a < DEPTH; a++) stuck[i][a] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero(0, "reset");
    check_idle_zero(1, "reset");
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;

    // Fault-free run, default latency.
    do_start(0);
    wait_run(0);
    chk("done_cycle", 0, -1, first_done[0], 66);
    chk("pass_lit", 0, -1, pass_s[0], 1);
    for (int j = 0; j < DEPTH; j++) chk("mem_final", 0, j, mem[0][j], 8'hAA);

    // Start re-pulsed while busy must be ignored.
    do_start(0);
    wait_k(0, 9);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_run(0);
    chk("done_cycle_restart", 0, -1, first_done[0], 66);

    // Bit 0 of word 3 stuck at 0: only R0 sees it.
    stuck[0][3] = 8'h01;
    do_start(0);
    wait_run(0);
    chk("err_lit", 0, -1, err_s[0], 1);
    chk("fa_lit", 0, -1, fa_s[0], 4'h3);
    chk("fd_lit", 0, -1, fd_s[0], 8'h54);
    chk("pass_fail_lit", 0, -1, pass_s[0], 0);

    // Healed RAM after a failing run: results cleared on start, then pass.
    stuck[0][3] = 8'h00;
    do_start(0);
    wait_run(0);
    chk("pass_healed", 0, -1, pass_s[0], 1);

    // Reset mid-R0 aborts the run.
    do_start(0);
    wait_k(0, 19);
    rst_s[0] = 1'b1;
    trk[0]   = 1'b0;
    @(negedge clk);
    check_idle_zero(0, "abort");
    rst_s[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_wr_en", 0, -1, wr_en_s[0], 0);
      chk("abort_busy", 0, -1, busy_s[0], 0);
    end
    do_start(0);
    wait_run(0);
    chk("pass_after_abort", 0, -1, pass_s[0], 1);

    // Two-cycle read latency.
    do_start(1);
    wait_run(1);
    chk("done_cycle_lat2", 1, -1, first_done[1], 68);
    chk("pass_lat2", 1, -1, pass_s[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
